// File: rtl/n64a_vdemux_param.sv
// Demultiplexes the N64 muxed video bus into sync plus NUM_CH colour channels,
// tracks stream lock over whole pixel periods and counts protocol errors.
module n64a_vdemux_param #(
  parameter int unsigned COLOR_W  = 7,
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                        VCLK,
  input  logic                        nRST,
  input  logic                        nVDSYNC,
  input  logic [COLOR_W-1:0]          VD_i,
  input  logic [2:0]                  demuxparams_i,
  output logic                        vdata_valid_0,
  output logic [3:0]                  vdata_sy_0,
  output logic                        vdata_valid_1,
  output logic [4+NUM_CH*COLOR_W-1:0] vdata_1,
  output logic                        locked_o,
  output logic [ERRCNT_W-1:0]         err_cnt_o
);

  localparam int unsigned SLOT_W = $clog2(NUM_CH + 2);
  localparam int unsigned COL_W  = NUM_CH * COLOR_W;
  localparam int unsigned PIX_W  = 4 + COL_W;
  localparam int unsigned GOOD_W = 4;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CH);
  localparam logic [SLOT_W-1:0] SLOT_OVF  = SLOT_W'(NUM_CH + 1);
  localparam logic [GOOD_W-1:0] GOOD_TOP  = GOOD_W'(LOCK_CNT - 1);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  logic                palmode;
  logic                ndo_deblur;
  logic                n16bit_mode;

  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [3:0]          sync0_q, sync0_d;
  logic                nblank_q, nblank_d;
  logic [PIX_W-1:0]    vdata_1_q, vdata_1_d;
  logic                valid_q, valid_d;
  lock_state_e         state_q, state_d;
  logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                sync_slot;
  logic                good_period;
  logic                err_event;

  assign palmode     = demuxparams_i[2];
  assign ndo_deblur  = demuxparams_i[1];
  assign n16bit_mode = demuxparams_i[0];

  // Reduced colour depth keeps the top 6 bits (green) or top 5 bits (others).
  function automatic logic [COLOR_W-1:0] reduce_col(input logic [COLOR_W-1:0] d,
                                                    input logic               keep6);
    logic [COLOR_W-1:0] r;
    r = d;
    for (int unsigned b = 0; b < COLOR_W; b++) begin
      if (keep6 ? (b + 6 < COLOR_W) : (b + 5 < COLOR_W)) begin
        r[b] = 1'b0;
      end
    end
    return r;
  endfunction

  // Slot counter and period classification.
  always_comb begin
    sync_slot   = ~nVDSYNC;
    good_period = sync_slot && (slot_q == SLOT_LAST);
    // Overrun is flagged only on the transition into the saturated value.
    err_event   = (sync_slot && (slot_q != SLOT_LAST)) ||
                  (!sync_slot && (slot_q == SLOT_LAST));

    slot_d = slot_q;
    if (sync_slot) begin
      slot_d = '0;
    end else if (slot_q != SLOT_OVF) begin
      slot_d = slot_q + SLOT_W'(1);
    end
  end

  // Datapath: stage-0 capture, output pixel load and deblur blanking.
  always_comb begin
    col_d     = col_q;
    sync0_d   = sync0_q;
    nblank_d  = nblank_q;
    vdata_1_d = vdata_1_q;

    if (sync_slot) begin
      vdata_1_d[3:0] = sync0_q;
      if (nblank_q) begin
        vdata_1_d[PIX_W-1:4] = col_q;
      end
      sync0_d = VD_i[3:0];

      if (ndo_deblur) begin
        nblank_d = 1'b1;
      end else if (!sync0_q[0] && VD_i[0]) begin
        nblank_d = palmode;
      end else begin
        nblank_d = ~nblank_q;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (slot_q == SLOT_W'(k)) begin
          col_d[k*COLOR_W +: COLOR_W] = n16bit_mode ? VD_i : reduce_col(VD_i, k == 1);
        end
      end
    end
  end

  // Lock FSM, valid strobe and error counter.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    valid_d    = good_period && (state_q == LOCKED);
    err_cnt_d  = err_cnt_q;

    if (err_event && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end

    case (state_q)
      UNLOCKED: begin
        if (err_event) begin
          good_cnt_d = '0;
        end else if (good_period) begin
          if (good_cnt_q == GOOD_TOP) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + GOOD_W'(1);
          end
        end
      end
      LOCKED: begin
        if (err_event) begin
          state_d = UNLOCKED;
        end
      end
      default: begin
        state_d    = UNLOCKED;
        good_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      slot_q     <= SLOT_OVF;
      col_q      <= '0;
      sync0_q    <= '0;
      nblank_q   <= 1'b1;
      vdata_1_q  <= '0;
      valid_q    <= 1'b0;
      state_q    <= UNLOCKED;
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      slot_q     <= slot_d;
      col_q      <= col_d;
      sync0_q    <= sync0_d;
      nblank_q   <= nblank_d;
      vdata_1_q  <= vdata_1_d;
      valid_q    <= valid_d;
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign vdata_valid_0 = valid_q;
  assign vdata_valid_1 = valid_q;
  assign vdata_sy_0    = sync0_q;
  assign vdata_1       = vdata_1_q;
  assign locked_o      = (state_q == LOCKED);
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_n64a_vdemux_param.sv
// Directed bench for n64a_vdemux_param: a period-level reference model is
// compared every cycle, plus hand-computed checks at the interesting points.
module tb_n64a_vdemux_param;

  localparam int CW  = 7;
  localparam int NCH = 3;
  localparam int LCK = 4;
  localparam int PW  = 4 + NCH * CW;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          nvd   = 1'b1;
  logic [CW-1:0] vd    = '0;
  logic [2:0]    dmx   = 3'b011;

  logic          v0, v1, lck;
  logic [3:0]    sy0;
  logic [PW-1:0] vdat;
  logic [7:0]    errc;

  logic          s_v0, s_v1, s_lck;
  logic [3:0]    s_sy0;
  logic [PW-1:0] s_vdat;
  logic [1:0]    s_errc;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  n64a_vdemux_param #(.COLOR_W(CW), .NUM_CH(NCH), .LOCK_CNT(LCK), .ERRCNT_W(8)) u_dut (
    .VCLK(clk), .nRST(rst_n), .nVDSYNC(nvd), .VD_i(vd), .demuxparams_i(dmx),
    .vdata_valid_0(v0), .vdata_sy_0(sy0), .vdata_valid_1(v1), .vdata_1(vdat),
    .locked_o(lck), .err_cnt_o(errc)
  );

  n64a_vdemux_param #(.COLOR_W(CW), .NUM_CH(NCH), .LOCK_CNT(LCK), .ERRCNT_W(2)) u_sat (
    .VCLK(clk), .nRST(rst_n), .nVDSYNC(nvd), .VD_i(vd), .demuxparams_i(dmx),
    .vdata_valid_0(s_v0), .vdata_sy_0(s_sy0), .vdata_valid_1(s_v1), .vdata_1(s_vdat),
    .locked_o(s_lck), .err_cnt_o(s_errc)
  );

  // ---------------- reference model (period-level view) ----------------
  bit      m_seen_low;
  int      m_hi;
  int      m_err;
  int      m_run;
  bit      m_locked;
  bit      m_valid;
  bit      m_nblank;
  bit [3:0] m_sync0;
  bit [3:0] m_out_sync;
  bit [CW-1:0] m_col [NCH];
  bit [CW-1:0] m_out_col [NCH];
  bit      m_good, m_errev, m_nb;

  function automatic bit [CW-1:0] m_reduce(input bit [CW-1:0] v, input int ch, input bit full);
    int s;
    if (full) return v;
    s = (ch == 1) ? CW - 6 : CW - 5;
    return (v >> s) << s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_seen_low = 0; m_hi = 0; m_err = 0; m_run = 0;
      m_locked = 0; m_valid = 0; m_nblank = 1;
      m_sync0 = '0; m_out_sync = '0;
      for (int c = 0; c < NCH; c++) begin
        m_col[c] = '0;
        m_out_col[c] = '0;
      end
    end else begin
      m_good  = !nvd && m_seen_low && (m_hi == NCH);
      m_errev = (!nvd && !m_good) || (nvd && m_seen_low && (m_hi == NCH));
      m_valid = m_good && m_locked;
      if (m_errev) m_err++;
      if (m_locked) begin
        if (m_errev) m_locked = 0;
      end else if (m_errev) begin
        m_run = 0;
      end else if (m_good) begin
        m_run++;
        if (m_run == LCK) begin
          m_locked = 1;
          m_run = 0;
        end
      end
      if (!nvd) begin
        m_out_sync = m_sync0;
        if (m_nblank) m_out_col = m_col;
        if (dmx[1]) m_nb = 1;
        else if (!m_sync0[0] && vd[0]) m_nb = dmx[2];
        else m_nb = !m_nblank;
        m_nblank = m_nb;
        m_sync0 = vd[3:0];
        m_seen_low = 1;
        m_hi = 0;
      end else begin
        if (m_seen_low && m_hi < NCH) m_col[m_hi] = m_reduce(vd, m_hi, dmx[0]);
        if (m_hi < 1000) m_hi++;
      end
    end
  end

  // ---------------- checking helpers ----------------
  function automatic int satv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [20:0] colv(input int n);
    return {7'(n * 8 + 3), 7'(n * 8 + 2), 7'(n * 8 + 1)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cmp_model();
    logic [PW-1:0] ev;
    ev[3:0] = m_out_sync;
    for (int c = 0; c < NCH; c++) ev[4 + c*CW +: CW] = m_out_col[c];
    chk("model valid_0", 32'(v0), 32'(m_valid));
    chk("model valid_1", 32'(v1), 32'(m_valid));
    chk("model sy_0", 32'(sy0), 32'(m_sync0));
    chk("model vdata_1", 32'(vdat), 32'(ev));
    chk("model locked", 32'(lck), 32'(m_locked));
    chk("model err_cnt", 32'(errc), 32'(satv(m_err, 255)));
    chk("model err_cnt_w2", 32'(s_errc), 32'(satv(m_err, 3)));
  endtask

  task automatic slot(input logic nv, input logic [CW-1:0] d);
    nvd = nv;
    vd  = d;
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic px(input int n);
    slot(1'b1, 7'(n * 8 + 1));
    slot(1'b1, 7'(n * 8 + 2));
    slot(1'b1, 7'(n * 8 + 3));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset locked", 32'(lck), 32'd0);
    chk("reset err_cnt", 32'(errc), 32'd0);
    chk("reset vdata_1", 32'(vdat), 32'd0);
    chk("reset valid", 32'(v0), 32'd0);
    chk("reset sy_0", 32'(sy0), 32'd0);
    rst_n = 1'b1;
    slot(1'b1, 7'h00);

    // Five clean periods: first low is an error, lock after the fifth low.
    for (int p = 1; p <= 5; p++) begin
      slot(1'b0, 7'h0F);
      if (p == 4) chk("lock not yet", 32'(lck), 32'd0);
      if (p == 5) begin
        chk("lock after 5th", 32'(lck), 32'd1);
        chk("first pixel", 32'(vdat), 32'({7'h7F, 7'h2A, 7'h55, 4'hF}));
        chk("err after reset", 32'(errc), 32'd1);
        chk("no valid yet", 32'(v1), 32'd0);
      end
      slot(1'b1, 7'h55);
      slot(1'b1, 7'h2A);
      slot(1'b1, 7'h7F);
    end
    slot(1'b0, 7'h0F);
    chk("valid once locked", 32'(v1), 32'd1);

    // Reduced colour depth.
    dmx = 3'b010;
    slot(1'b1, 7'h7F);
    slot(1'b1, 7'h7F);
    slot(1'b1, 7'h7F);
    slot(1'b0, 7'h0F);
    chk("reduced colour", 32'(vdat[PW-1:4]), 32'({7'h7C, 7'h7E, 7'h7C}));
    dmx = 3'b011;
    px(1);

    // Short period while locked.
    slot(1'b0, 7'h0F);
    chk("valid locked", 32'(v0), 32'd1);
    slot(1'b1, 7'h01);
    slot(1'b1, 7'h02);
    slot(1'b0, 7'h0F);
    chk("short: unlock", 32'(lck), 32'd0);
    chk("short: no valid", 32'(v1), 32'd0);
    chk("short: err", 32'(errc), 32'd2);
    px(2);
    for (int i = 1; i <= 4; i++) begin
      slot(1'b0, 7'h0F);
      chk("relock", 32'(lck), 32'(i == 4));
      px(2 + i);
    end

    // Deblur alternation after a csync rising edge, then deblur off.
    slot(1'b0, 7'h0F);
    px(0);
    dmx = 3'b001;
    slot(1'b0, 7'h0E); chk("deblur A", 32'(vdat[PW-1:4]), 32'(colv(0))); px(1);
    slot(1'b0, 7'h0F); chk("deblur B", 32'(vdat[PW-1:4]), 32'(colv(0))); px(2);
    slot(1'b0, 7'h0F); chk("deblur C held", 32'(vdat[PW-1:4]), 32'(colv(0))); px(3);
    slot(1'b0, 7'h0F); chk("deblur D pass", 32'(vdat[PW-1:4]), 32'(colv(3))); px(4);
    slot(1'b0, 7'h0F); chk("deblur E held", 32'(vdat[PW-1:4]), 32'(colv(3))); px(5);
    slot(1'b0, 7'h0F); chk("deblur F pass", 32'(vdat[PW-1:4]), 32'(colv(5)));
    dmx = 3'b011;
    px(6);
    slot(1'b0, 7'h0F); px(7);
    slot(1'b0, 7'h0F); chk("nodeblur H", 32'(vdat[PW-1:4]), 32'(colv(7))); px(8);
    slot(1'b0, 7'h0F); chk("nodeblur I", 32'(vdat[PW-1:4]), 32'(colv(8)));

    // Long high run and counter saturation.
    px(9);
    chk("hold: err before", 32'(errc), 32'd2);
    repeat (20) slot(1'b1, 7'h11);
    chk("hold: one error", 32'(errc), 32'd3);
    chk("hold: w2 err", 32'(s_errc), 32'd3);
    slot(1'b0, 7'h0F);
    slot(1'b0, 7'h0F);
    chk("err count 5", 32'(errc), 32'd5);
    chk("w2 saturated", 32'(s_errc), 32'd3);

    // Relock, then asynchronous reset mid-pixel.
    px(10);
    for (int i = 1; i <= 4; i++) begin
      slot(1'b0, 7'h0F);
      chk("pre-reset lock", 32'(lck), 32'(i == 4));
      px(i);
    end
    slot(1'b0, 7'h0F);
    slot(1'b1, 7'h22);
    #2 rst_n = 1'b0;
    #1;
    chk("async locked", 32'(lck), 32'd0);
    chk("async err_cnt", 32'(errc), 32'd0);
    chk("async vdata_1", 32'(vdat), 32'd0);
    chk("async sy_0", 32'(sy0), 32'd0);
    chk("async valid", 32'(v0 | v1), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      slot(1'b0, 7'h0F);
      chk("post-reset lock", 32'(lck), 32'(i == 5));
      px(10 + i);
    end
    chk("post-reset err", 32'(errc), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
